alu_mult_sequencer: RTL and testbench
=====================================

Name: alu_mult_sequencer

Overview:
- Iterative shift-add 64x64 unsigned multiplier, low 64-bit product.
- Owns no adder; borrows the shared 64-bit datapath ALU through a req/gnt handshake, one add per granted cycle.
- Sits beside the execute stage; the pipeline stalls on busy and arbitrates ALU ownership.

Parameters:
- WIDTH, 64, operand, product and ALU width.
- EARLY_EXIT, 1, when 1, finish as soon as the remaining multiplier bits are all zero.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin; sampled only in IDLE
- op_a  in  WIDTH  multiplicand, captured on accepted start
- op_b  in  WIDTH  multiplier, captured on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, product valid
- product  out  WIDTH  low WIDTH bits of op_a*op_b; held until next accepted start
- product_ovf  out  1  true unsigned product exceeded WIDTH bits; held with product
- alu_req  out  1  sequencer wants the ALU this cycle
- alu_gnt  in  1  ALU granted this cycle
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_cntrl  out  3  ALU op code
- alu_result  in  WIDTH  ALU result, same cycle (combinational)
- alu_carry_out  in  1  ALU carry out, same cycle

Behaviour:
- Reset (reset==0 at edge): state IDLE; busy=0, done=0, product=0, product_ovf=0, alu_req=0; internal acc, mcand, mplier, count, lost all 0. Applies mid-operation; any in-flight multiply is discarded, no done pulse.
- ALU drive: alu_cntrl=3'b010 (add) whenever alu_req=1; else 3'b000 with alu_a=alu_b=0.
- IDLE: if start, latch mcand=op_a, mplier=op_b, acc=0, count=0, lost=0, ovf_acc=0, go RUN. start is ignored in RUN and DONE, with no queuing.
- RUN: alu_req=1, alu_a=acc, alu_b=(mplier[0] ? mcand : 0).
  - alu_gnt=0: hold all state; stall length unbounded.
  - alu_gnt=1: acc<=alu_result; if mplier[0], ovf_acc |= alu_carry_out | lost; lost |= mcand[WIDTH-1]; mcand<<=1; mplier>>=1; count++.
  - Exit to DONE on a granted cycle when count==WIDTH-1, or when EARLY_EXIT=1 and (mplier>>1)==0.
- DONE (one cycle): product<=acc, product_ovf<=ovf_acc, done=1, alu_req=0, go IDLE. New start is accepted the following cycle.
- Latency with continuous grant: with EARLY_EXIT=0, done asserts WIDTH+1 cycles after the start edge. With EARLY_EXIT=1, done follows k+1 cycles after the start edge, where k=max(1, index of the highest set bit of op_b plus 1).
- op_b==0: one RUN cycle (add 0), product=0, product_ovf=0.
- Wrap-around: acc and mcand are truncated to WIDTH. Overflow detection is exact for unsigned operands.

Decomposition:
- Shared package (alu_pkg): ALU op-code constants ALU_PASS_B=3'b000, ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_AND, ALU_OR, ALU_XOR; state enum type mseq_state_t {IDLE, RUN, DONE}.
- Single module. Operand shift registers and counter are inline; no sub-module is needed.

Test Plan:
- gnt tied 1, EARLY_EXIT=0, op_a=7, op_b=6 -> done exactly 65 cycles after start, product=42, product_ovf=0, alu_cntrl=010 throughout RUN.
- EARLY_EXIT=1, op_a=0x1234, op_b=0x5 -> done 4 cycles after start, product=0x5B04; op_b=0 -> done 2 cycles after start, product=0.
- op_a=2^63, op_b=2 -> product=0, product_ovf=1. op_a=2^64-1, op_b=1 -> product=2^64-1, product_ovf=0. op_a=2^32, op_b=2^32 -> product=0, product_ovf=1.
- alu_gnt toggled pseudo-randomly 50% with op_a=123456789, op_b=987654321 -> product=121932631112635269, state frozen on gnt=0 cycles, start pulses during busy ignored.
- reset driven low for one cycle mid-RUN -> next cycle busy=0, done=0, product=0, alu_req=0; a fresh start then completes correctly.
- Back-to-back: start on the cycle after done -> accepted; the previous product stays stable until the new done.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared datapath ALU op codes and the multiply sequencer state type.
package alu_pkg;

   localparam logic [2:0] ALU_PASS_B = 3'b000;
   localparam logic [2:0] ALU_ADD    = 3'b010;
   localparam logic [2:0] ALU_SUB    = 3'b011;
   localparam logic [2:0] ALU_AND    = 3'b100;
   localparam logic [2:0] ALU_OR     = 3'b101;
   localparam logic [2:0] ALU_XOR    = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mseq_state_t;

endpackage

// File: rtl/alu_mult_sequencer.sv
// Iterative shift-add unsigned multiplier producing the low WIDTH product bits,
// borrowing the shared datapath ALU for one add per granted cycle.
module alu_mult_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             product_ovf,
   output logic             alu_req,
   input  logic             alu_gnt,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_cntrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry_out
);

   localparam int unsigned CW = $clog2(WIDTH);

   mseq_state_t      state_q, state_d;
   logic [WIDTH-1:0] acc, mcand, mplier;
   logic [CW-1:0]    count;
   logic             lost, ovf_acc, last;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      alu_req   = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_cntrl = ALU_PASS_B;
      last      = (count == CW'(WIDTH - 1)) ||
                  ((EARLY_EXIT != 0) && ((mplier >> 1) == '0));
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            alu_req   = 1'b1;
            alu_cntrl = ALU_ADD;
            alu_a     = acc;
            alu_b     = mplier[0] ? mcand : '0;
            if (alu_gnt && last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   // lost remembers any multiplicand bit shifted past the top; adding a
   // shifted multiplicand after such a loss means the true product overflowed.
   always_ff @(posedge clk) begin
      if (!reset) begin
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         count       <= '0;
         lost        <= 1'b0;
         ovf_acc     <= 1'b0;
         product     <= '0;
         product_ovf <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand   <= op_a;
                  mplier  <= op_b;
                  acc     <= '0;
                  count   <= '0;
                  lost    <= 1'b0;
                  ovf_acc <= 1'b0;
               end
            end
            RUN: begin
               if (alu_gnt) begin
                  acc <= alu_result;
                  if (mplier[0]) ovf_acc <= ovf_acc | alu_carry_out | lost;
                  lost   <= lost | mcand[WIDTH-1];
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count + 1'b1;
               end
            end
            DONE: begin
               product     <= acc;
               product_ovf <= ovf_acc;
               done        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench: one sequencer without and one with early exit, fed identical
// stimulus, each with its own behavioural adder standing in for the shared ALU.
module tb_alu_mult_sequencer;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [63:0] op_a, op_b;
   logic        gnt;

   logic        busy0, done0, ovf0, req0, c0;
   logic [63:0] prod0, a0, b0, r0;
   logic [2:0]  cn0;
   logic        busy1, done1, ovf1, req1, c1;
   logic [63:0] prod1, a1, b1, r1;
   logic [2:0]  cn1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_mult_sequencer #(.WIDTH(64), .EARLY_EXIT(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy0), .done(done0), .product(prod0), .product_ovf(ovf0),
      .alu_req(req0), .alu_gnt(gnt), .alu_a(a0), .alu_b(b0), .alu_cntrl(cn0),
      .alu_result(r0), .alu_carry_out(c0));

   alu_mult_sequencer #(.WIDTH(64), .EARLY_EXIT(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy1), .done(done1), .product(prod1), .product_ovf(ovf1),
      .alu_req(req1), .alu_gnt(gnt), .alu_a(a1), .alu_b(b1), .alu_cntrl(cn1),
      .alu_result(r1), .alu_carry_out(c1));

   always_comb begin
      {c0, r0} = (cn0 == 3'b010) ? ({1'b0, a0} + {1'b0, b0}) : {1'b0, b0};
      {c1, r1} = (cn1 == 3'b010) ? ({1'b0, a1} + {1'b0, b1}) : {1'b0, b1};
   end

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] p;
      logic        ovf;
      int          lat1;
   } vec_t;

   vec_t        vecs[9];
   logic [63:0] prev_p0 = '0, prev_p1 = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Starts one multiply on both DUTs and runs until both have pulsed done.
   task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                         input bit rnd, input bit poke,
                         output int lat0, output int lat1,
                         output logic [63:0] p0, output logic [63:0] p1,
                         output logic v0, output logic v1);
      bit          seen0 = 0, seen1 = 0;
      bit          drive_ok = 1, held_ok = 1, frz_ok = 1;
      logic        pr0, pr1, pg;
      logic [63:0] pa0, pb0, pa1, pb1;
      lat0 = -1; lat1 = -1; p0 = '0; p1 = '0; v0 = 0; v1 = 0;
      op_a = a; op_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      gnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pr0 = req0; pr1 = req1; pg = gnt; pa0 = a0; pb0 = b0; pa1 = a1; pb1 = b1;
      for (int n = 1; n <= 1000 && !(seen0 && seen1); n++) begin
         @(posedge clk); #1;
         if (req0 ? (cn0 !== ALU_ADD || !busy0) : (cn0 !== ALU_PASS_B || a0 !== '0 || b0 !== '0)) drive_ok = 0;
         if (req1 ? (cn1 !== ALU_ADD || !busy1) : (cn1 !== ALU_PASS_B || a1 !== '0 || b1 !== '0)) drive_ok = 0;
         if (pr0 && !pg && (!req0 || a0 !== pa0 || b0 !== pb0)) frz_ok = 0;
         if (pr1 && !pg && (!req1 || a1 !== pa1 || b1 !== pb1)) frz_ok = 0;
         if (!seen0 && !done0 && prod0 !== prev_p0) held_ok = 0;
         if (!seen1 && !done1 && prod1 !== prev_p1) held_ok = 0;
         if (done0 && !seen0) begin seen0 = 1; lat0 = n; p0 = prod0; v0 = ovf0; end
         if (done1 && !seen1) begin seen1 = 1; lat1 = n; p1 = prod1; v1 = ovf1; end
         gnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke && busy0 && busy1 && (n % 7 == 3)) begin
            start = 1'b1; op_a = ~a; op_b = ~b;
         end else begin
            start = 1'b0; op_a = a; op_b = b;
         end
         pr0 = req0; pr1 = req1; pg = gnt; pa0 = a0; pb0 = b0; pa1 = a1; pb1 = b1;
      end
      start = 1'b0;
      gnt   = 1'b1;
      chk("completed_in_budget", {62'b0, seen1, seen0}, 64'd3);
      chk("alu_drive", {63'b0, drive_ok}, 64'd1);
      chk("product_held", {63'b0, held_ok}, 64'd1);
      if (rnd) chk("frozen_on_nogrant", {63'b0, frz_ok}, 64'd1);
   endtask

   initial begin
      int          l0, l1;
      logic [63:0] p0, p1;
      logic        v0, v1;

      vecs[0] = '{64'd7, 64'd6, 64'd42, 1'b0, 4};
      vecs[1] = '{64'h1234, 64'h5, 64'h5B04, 1'b0, 4};
      vecs[2] = '{64'h1234, 64'h0, 64'h0, 1'b0, 2};
      vecs[3] = '{64'h8000_0000_0000_0000, 64'd2, 64'h0, 1'b1, 3};
      vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2};
      vecs[5] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'h0, 1'b1, 34};
      vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 65};
      vecs[7] = '{64'h1_0000_0001, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 33};
      vecs[8] = '{64'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 65};

      reset = 1'b0; start = 1'b0; op_a = '0; op_b = '0; gnt = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy",    {62'b0, busy0, busy1}, 64'd0);
      chk("reset_done",    {62'b0, done0, done1}, 64'd0);
      chk("reset_req",     {62'b0, req0, req1},   64'd0);
      chk("reset_product", prod0 | prod1,         64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // table vectors, issued back to back with continuous grant
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, 1'b0, 1'b0, l0, l1, p0, p1, v0, v1);
         chk($sformatf("v%0d_prod_noee", i), p0, vecs[i].p);
         chk($sformatf("v%0d_ovf_noee", i), {63'b0, v0}, {63'b0, vecs[i].ovf});
         chk($sformatf("v%0d_lat_noee", i), 64'(l0), 64'd65);
         chk($sformatf("v%0d_prod_ee", i), p1, vecs[i].p);
         chk($sformatf("v%0d_ovf_ee", i), {63'b0, v1}, {63'b0, vecs[i].ovf});
         chk($sformatf("v%0d_lat_ee", i), 64'(l1), 64'(vecs[i].lat1));
         prev_p0 = vecs[i].p;
         prev_p1 = vecs[i].p;
      end

      // intermittent grant with start pulses while busy
      run_op(64'd123456789, 64'd987654321, 1'b1, 1'b1, l0, l1, p0, p1, v0, v1);
      chk("rnd_prod_noee", p0, 64'd121932631112635269);
      chk("rnd_prod_ee",   p1, 64'd121932631112635269);
      chk("rnd_ovf",       {62'b0, v0, v1}, 64'd0);
      prev_p0 = 64'd121932631112635269;
      prev_p1 = 64'd121932631112635269;

      // one-cycle reset in the middle of a run
      op_a = 64'hDEAD_BEEF; op_b = 64'hFFFF_FFFF_FFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_reset_busy", {62'b0, busy0, busy1}, 64'd3);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      chk("midrst_busy",    {62'b0, busy0, busy1}, 64'd0);
      chk("midrst_done",    {62'b0, done0, done1}, 64'd0);
      chk("midrst_req",     {62'b0, req0, req1},   64'd0);
      chk("midrst_product", prod0 | prod1,         64'd0);
      prev_p0 = '0;
      prev_p1 = '0;
      @(posedge clk); #1;
      run_op(64'd7, 64'd6, 1'b0, 1'b0, l0, l1, p0, p1, v0, v1);
      chk("post_rst_prod_noee", p0, 64'd42);
      chk("post_rst_prod_ee",   p1, 64'd42);
      chk("post_rst_lat_noee",  64'(l0), 64'd65);
      chk("post_rst_lat_ee",    64'(l1), 64'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
